z80_bus_arbiter: RTL and testbench

Arbiter that shares the Z80 work RAM between the Z80 core and an external host, such as a bench loader or the 68k side. It uses the Z80 BUSRQ/BUSAK handshake. While the Z80 owns the bus, the block passes Z80 memory writes through to the RAM port. After BUSAK, it grants the bus to the host and sequences single-byte host accesses. It sits between `z80cpu`, the RAM model and the host.

---
 rtl/z80_bus_arbiter.sv | 168 ++++++++++++++++
 tb/tb_z80_bus_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_arbiter.sv
// Shares Z80 work RAM between the Z80 core and a host through the BUSRQ/BUSAK handshake.
// Define ZARB_TIMEOUT_EN to build the BUSAK timeout counter and a live TIMEOUT_ERR.
module z80_bus_arbiter #(
  parameter logic [15:0] RAM_BASE = 16'h4000,
  parameter int          TIMEOUT  = 1024
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        HOST_REQ,
  output logic        HOST_ACK,
  input  logic        HOST_STB,
  input  logic        HOST_WE,
  input  logic [15:0] HOST_ADDR,
  input  logic [7:0]  HOST_WDATA,
  output logic [7:0]  HOST_RDATA,
  output logic        HOST_DONE,
  output logic        TIMEOUT_ERR,
  output logic        ZBUSRQ_n,
  input  logic        ZBUSAK_n,
  input  logic [15:0] ZADDR,
  input  logic [7:0]  ZWDATA,
  input  logic        ZMREQ_n,
  input  logic        ZWR_n,
  output logic [15:0] RAM_ADDR,
  output logic [7:0]  RAM_WDATA,
  output logic        RAM_WE,
  input  logic [7:0]  RAM_RDATA
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_SETUP,
    ACC_STROBE
  } acc_t;

  state_t      state_q, state_d;
  acc_t        acc_q, acc_d;
  logic        busak_m, busak_s;
  logic [15:0] acc_addr_q;
  logic [7:0]  acc_wdata_q;
  logic        acc_we_q;
  logic [7:0]  rdata_q;
  logic        done_q;
  logic        tmo_err_q;
  logic        tmo_hit;
  logic        accept;

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      busak_m <= 1'b1;
      busak_s <= 1'b1;
    end else begin
      busak_m <= ZBUSAK_n;
      busak_s <= busak_m;
    end
  end

`ifdef ZARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  // Counter sits at zero outside REQ, so every REQ entry starts a fresh count.
  always_ff @(posedge MCLK) begin
    if (RESET || state_q != ST_REQ) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  assign tmo_hit = (state_q == ST_REQ) && (tmo_cnt_q == TMO_LAST);

  always_ff @(posedge MCLK) begin
    if (RESET || !HOST_REQ) begin
      tmo_err_q <= 1'b0;
    end else if (tmo_hit && busak_s) begin
      tmo_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign tmo_err_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (HOST_REQ && !tmo_err_q) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!busak_s) begin
          state_d = ST_GRANT;
        end else if (!HOST_REQ || tmo_hit) begin
          state_d = ST_RELEASE;
        end
      end
      ST_GRANT: begin
        // A host that has dropped its request starts no new access, so release cannot be starved.
        accept = HOST_STB && HOST_REQ && (acc_q != ACC_SETUP);
        case (acc_q)
          ACC_IDLE:   if (accept) acc_d = ACC_SETUP;
          ACC_SETUP:  acc_d = ACC_STROBE;
          ACC_STROBE: acc_d = accept ? ACC_SETUP : ACC_IDLE;
          default:    acc_d = ACC_IDLE;
        endcase
        if (!HOST_REQ && acc_q == ACC_IDLE) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (busak_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_IDLE;
      acc_addr_q  <= '0;
      acc_wdata_q <= '0;
      acc_we_q    <= 1'b0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (accept) begin
        acc_addr_q  <= HOST_ADDR;
        acc_wdata_q <= HOST_WDATA;
        acc_we_q    <= HOST_WE;
      end
      done_q <= (state_q == ST_GRANT) && (acc_q == ACC_STROBE);
      if (state_q == ST_GRANT && acc_q == ACC_STROBE && !acc_we_q) begin
        rdata_q <= (acc_addr_q >= RAM_BASE) ? RAM_RDATA : 8'hFF;
      end
    end
  end

  always_comb begin
    RAM_ADDR  = ZADDR;
    RAM_WDATA = ZWDATA;
    RAM_WE    = !ZMREQ_n && !ZWR_n && (ZADDR >= RAM_BASE);
    if (state_q == ST_GRANT) begin
      RAM_ADDR  = acc_addr_q;
      RAM_WDATA = acc_wdata_q;
      RAM_WE    = (acc_q == ACC_STROBE) && acc_we_q && (acc_addr_q >= RAM_BASE);
    end
  end

  assign HOST_ACK    = (state_q == ST_GRANT);
  assign ZBUSRQ_n    = !((state_q == ST_REQ) || (state_q == ST_GRANT));
  assign HOST_RDATA  = rdata_q;
  assign HOST_DONE   = done_q;
  assign TIMEOUT_ERR = tmo_err_q;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Randomized scoreboard bench for z80_bus_arbiter with a byte-array RAM and a BUSAK responder.
// Host access results are predicted from a memory map model and checked whenever HOST_DONE pulses.
module tb_z80_bus_arbiter;

  localparam logic [15:0] RAM_BASE = 16'h4000;
  localparam int          TIMEOUT  = 16;

  logic        MCLK;
  logic        RESET;
  logic        HOST_REQ;
  logic        HOST_ACK;
  logic        HOST_STB;
  logic        HOST_WE;
  logic [15:0] HOST_ADDR;
  logic [7:0]  HOST_WDATA;
  logic [7:0]  HOST_RDATA;
  logic        HOST_DONE;
  logic        TIMEOUT_ERR;
  logic        ZBUSRQ_n;
  logic        ZBUSAK_n = 1'b1;
  logic [15:0] ZADDR;
  logic [7:0]  ZWDATA;
  logic        ZMREQ_n;
  logic        ZWR_n;
  logic [15:0] RAM_ADDR;
  logic [7:0]  RAM_WDATA;
  logic        RAM_WE;
  logic [7:0]  RAM_RDATA;

  typedef struct {
    int          issue_edge;
    bit          we;
    logic [7:0]  exp_rdata;
    logic [15:0] addr;
  } exp_t;

  int         cyc = 0;
  int         n_compared = 0;
  int         n_mismatched = 0;
  logic [7:0] ram [0:65535];
  logic [7:0] ref_mem [int];
  exp_t       exp_q [$];
  exp_t       mon_e;
  int         last_accept = -100;
  bit         ack_enable = 1'b1;
  int         ack_delay = 5;
  int         rq_low_cnt = 0;
  int         busak_fall_cyc = -1;

  z80_bus_arbiter #(
    .RAM_BASE(RAM_BASE),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .MCLK       (MCLK),
    .RESET      (RESET),
    .HOST_REQ   (HOST_REQ),
    .HOST_ACK   (HOST_ACK),
    .HOST_STB   (HOST_STB),
    .HOST_WE    (HOST_WE),
    .HOST_ADDR  (HOST_ADDR),
    .HOST_WDATA (HOST_WDATA),
    .HOST_RDATA (HOST_RDATA),
    .HOST_DONE  (HOST_DONE),
    .TIMEOUT_ERR(TIMEOUT_ERR),
    .ZBUSRQ_n   (ZBUSRQ_n),
    .ZBUSAK_n   (ZBUSAK_n),
    .ZADDR      (ZADDR),
    .ZWDATA     (ZWDATA),
    .ZMREQ_n    (ZMREQ_n),
    .ZWR_n      (ZWR_n),
    .RAM_ADDR   (RAM_ADDR),
    .RAM_WDATA  (RAM_WDATA),
    .RAM_WE     (RAM_WE),
    .RAM_RDATA  (RAM_RDATA)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  always @(posedge MCLK) cyc <= cyc + 1;

  always @(posedge MCLK) if (RAM_WE) ram[RAM_ADDR] <= RAM_WDATA;
  assign RAM_RDATA = ram[RAM_ADDR];

  function automatic logic [7:0] init_pat(input logic [15:0] a);
    return a[15:8] ^ a[7:0] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    if (a < RAM_BASE) return 8'hFF;
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_pat(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // Issues one host strobe at the current negedge; the model decides whether the block accepts it.
  task automatic applyStimulus(input bit we, input logic [15:0] addr, input logic [7:0] data);
    int edge_no;
    edge_no    = cyc + 1;
    HOST_STB   = 1'b1;
    HOST_WE    = we;
    HOST_ADDR  = addr;
    HOST_WDATA = data;
    if (edge_no - last_accept >= 2) begin
      last_accept = edge_no;
      if (we) begin
        if (addr >= RAM_BASE) ref_mem[int'(addr)] = data;
        exp_q.push_back('{edge_no, 1'b1, 8'h00, addr});
      end else begin
        exp_q.push_back('{edge_no, 1'b0, ref_read(addr), addr});
      end
    end
    @(negedge MCLK);
    HOST_STB = 1'b0;
  endtask

  task automatic waitAck();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      got = HOST_ACK;
    end
    checkOutput("ack_wait", 32'(got), 32'd1);
  endtask

  task automatic z80Write(input logic [15:0] addr, input logic [7:0] data, input bit exp_we);
    ZADDR   = addr;
    ZWDATA  = data;
    ZMREQ_n = 1'b0;
    ZWR_n   = 1'b0;
    #1;
    checkOutput("z80_ram_we", 32'(RAM_WE), 32'(exp_we));
    if (exp_we) begin
      checkOutput("z80_ram_addr", 32'(RAM_ADDR), 32'(addr));
      checkOutput("z80_ram_wdata", 32'(RAM_WDATA), 32'(data));
      ref_mem[int'(addr)] = data;
    end
    @(negedge MCLK);
    ZMREQ_n = 1'b1;
    ZWR_n   = 1'b1;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_zbusrq_n"}, 32'(ZBUSRQ_n), 32'd1);
    checkOutput({tag, "_host_ack"}, 32'(HOST_ACK), 32'd0);
    checkOutput({tag, "_host_done"}, 32'(HOST_DONE), 32'd0);
    checkOutput({tag, "_host_rdata"}, 32'(HOST_RDATA), 32'h00);
    checkOutput({tag, "_timeout_err"}, 32'(TIMEOUT_ERR), 32'd0);
  endtask

  // Minimal Z80: grants the bus a few cycles after BUSRQ and releases as soon as BUSRQ rises.
  always @(negedge MCLK) begin
    if (!ack_enable || ZBUSRQ_n) begin
      rq_low_cnt = 0;
      ZBUSAK_n   = 1'b1;
    end else if (ZBUSAK_n) begin
      rq_low_cnt++;
      if (rq_low_cnt >= ack_delay) begin
        ZBUSAK_n       = 1'b0;
        busak_fall_cyc = cyc;
      end
    end
  end

  always @(posedge MCLK) begin
    #1;
    if (HOST_DONE) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("done_latency", 32'(cyc - mon_e.issue_edge), 32'd2);
        if (!mon_e.we) checkOutput("host_rdata", 32'(HOST_RDATA), 32'(mon_e.exp_rdata));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          got;
    int          low;
    logic [15:0] addr;
    logic [31:0] r;

    RESET      = 1'b1;
    HOST_REQ   = 1'b0;
    HOST_STB   = 1'b0;
    HOST_WE    = 1'b0;
    HOST_ADDR  = '0;
    HOST_WDATA = '0;
    ZADDR      = '0;
    ZWDATA     = '0;
    ZMREQ_n    = 1'b1;
    ZWR_n      = 1'b1;
    for (int i = 0; i < 65536; i++) ram[i] = init_pat(16'(i));

    repeat (3) @(posedge MCLK);
    #1;
    checkResetOutputs("reset");
    checkOutput("reset_ram_we", 32'(RAM_WE), 32'd0);
    @(negedge MCLK);
    RESET = 1'b0;

    $display("[TB] Z80 pass-through in IDLE");
    @(negedge MCLK);
    z80Write(16'h8000, 8'h5A, 1'b1);
    z80Write(16'h1234, 8'h77, 1'b0);
    z80Write(16'h3FFF, 8'h11, 1'b0);
    z80Write(16'h4000, 8'h22, 1'b1);

    $display("[TB] bus request handshake");
    @(negedge MCLK);
    HOST_REQ = 1'b1;
    tick();
    checkOutput("busrq_latency", 32'(ZBUSRQ_n), 32'd0);
    checkOutput("ack_before_busak", 32'(HOST_ACK), 32'd0);
    waitAck();
    checkOutput("ack_latency", 32'(cyc - busak_fall_cyc), 32'd3);

    @(negedge MCLK);
    ZADDR   = 16'h8002;
    ZWDATA  = 8'hEE;
    ZMREQ_n = 1'b0;
    ZWR_n   = 1'b0;
    repeat (2) begin
      #1;
      checkOutput("grant_z80_we_blocked", 32'(RAM_WE), 32'd0);
      @(negedge MCLK);
    end
    ZMREQ_n = 1'b1;
    ZWR_n   = 1'b1;

    $display("[TB] directed host accesses");
    applyStimulus(1'b1, 16'h9000, 8'hA5);
    tick();
    checkOutput("host_we_pulse", 32'(RAM_WE), 32'd1);
    checkOutput("host_ram_addr", 32'(RAM_ADDR), 32'h9000);
    checkOutput("host_ram_wdata", 32'(RAM_WDATA), 32'hA5);
    tick();
    checkOutput("host_we_single", 32'(RAM_WE), 32'd0);
    @(negedge MCLK);
    applyStimulus(1'b0, 16'h9000, 8'h00);
    repeat (3) @(negedge MCLK);
    applyStimulus(1'b1, 16'h9004, 8'h33);
    applyStimulus(1'b1, 16'h9004, 8'h44);
    @(negedge MCLK);
    applyStimulus(1'b0, 16'h9004, 8'h00);
    repeat (2) @(negedge MCLK);
    applyStimulus(1'b0, 16'h8002, 8'h00);
    applyStimulus(1'b0, 16'h8000, 8'h00);
    applyStimulus(1'b0, 16'h0010, 8'h00);
    @(negedge MCLK);
    applyStimulus(1'b1, 16'h0010, 8'h99);
    repeat (3) begin
      tick();
      checkOutput("rom_write_we", 32'(RAM_WE), 32'd0);
    end
    @(negedge MCLK);
    applyStimulus(1'b1, 16'h4000, 8'h42);
    @(negedge MCLK);
    applyStimulus(1'b0, 16'h3FFF, 8'h00);
    @(negedge MCLK);
    applyStimulus(1'b0, 16'h4000, 8'h00);

    $display("[TB] randomized host accesses");
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge MCLK);
      r = $urandom();
      case ($urandom_range(0, 2))
        0:       addr = 16'h3FF8 + 16'(r[3:0]);
        1:       addr = 16'h9000 + 16'(r[3:0]);
        default: addr = r[31:16];
      endcase
      applyStimulus(1'($urandom_range(0, 1)), addr, r[7:0]);
    end
    repeat (4) @(negedge MCLK);

    $display("[TB] host request dropped during an access");
    applyStimulus(1'b0, 16'h9000, 8'h00);
    HOST_REQ = 1'b0;
    tick();
    checkOutput("drop_busrq_hold1", 32'(ZBUSRQ_n), 32'd0);
    tick();
    checkOutput("drop_done", 32'(HOST_DONE), 32'd1);
    checkOutput("drop_busrq_hold2", 32'(ZBUSRQ_n), 32'd0);
    tick();
    checkOutput("drop_busrq_release", 32'(ZBUSRQ_n), 32'd1);
    checkOutput("drop_ack_release", 32'(HOST_ACK), 32'd0);
    repeat (6) @(negedge MCLK);
    z80Write(16'h8001, 8'h77, 1'b1);

    $display("[TB] reset during grant");
    HOST_REQ = 1'b1;
    waitAck();
    @(negedge MCLK);
    applyStimulus(1'b0, 16'h9001, 8'h00);
    RESET    = 1'b1;
    HOST_REQ = 1'b0;
    exp_q.delete();
    last_accept = -100;
    tick();
    checkResetOutputs("midreset");
    tick();
    checkOutput("midreset_no_done", 32'(HOST_DONE), 32'd0);
    @(negedge MCLK);
    RESET = 1'b0;

    $display("[TB] BUSAK never arrives");
    ack_enable = 1'b0;
    repeat (3) @(negedge MCLK);
    HOST_REQ = 1'b1;
`ifdef ZARB_TIMEOUT_EN
    low = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (!ZBUSRQ_n) low++;
      got = TIMEOUT_ERR;
    end
    checkOutput("timeout_err_set", 32'(got), 32'd1);
    checkOutput("timeout_req_cycles", 32'(low), 32'(TIMEOUT));
    checkOutput("timeout_busrq_release", 32'(ZBUSRQ_n), 32'd1);
    repeat (5) tick();
    checkOutput("timeout_no_retry", 32'(ZBUSRQ_n), 32'd1);
    checkOutput("timeout_err_sticky", 32'(TIMEOUT_ERR), 32'd1);
    @(negedge MCLK);
    HOST_REQ = 1'b0;
    tick();
    checkOutput("timeout_err_clear", 32'(TIMEOUT_ERR), 32'd0);
`else
    low = 0;
    repeat (40) begin
      tick();
      if (!ZBUSRQ_n) low++;
    end
    checkOutput("req_persists", 32'(low), 32'd40);
    checkOutput("no_timeout_err", 32'(TIMEOUT_ERR), 32'd0);
    @(negedge MCLK);
    HOST_REQ = 1'b0;
    tick();
    checkOutput("req_abandoned", 32'(ZBUSRQ_n), 32'd1);
`endif

    repeat (5) @(negedge MCLK);
    checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
